// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin arbiter sharing one CORDIC unit among three requesters.
// An operation that sees no crd_done within TIMEOUT_CYC wait cycles ends with rsp_err set.
module cordic_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [71:0] req_x,
  input  logic [71:0] req_y,
  output logic [2:0]  ack,
  output logic [2:0]  rsp_valid,
  output logic [23:0] rsp_angle,
  output logic [23:0] rsp_magnitude,
  output logic        rsp_err,
  output logic        busy,
  output logic [23:0] crd_x,
  output logic [23:0] crd_y,
  output logic        crd_start,
  input  logic        crd_done,
  input  logic [23:0] crd_angle,
  input  logic [23:0] crd_magnitude
);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);
  state_t      state_q;
  logic [1:0]  grant_q, rr_q;
  logic [7:0]  cnt_q;
  logic [2:0]  ack_q, rsp_valid_q;
  logic [23:0] crd_x_q, crd_y_q, ang_q, mag_q;
  logic        err_q, crd_start_q;
  logic [1:0]  nxt1_d, nxt2_d, win_d;
  logic [23:0] x_d, y_d;
  always_comb begin
    nxt1_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
    nxt2_d = (rr_q == 2'd0) ? 2'd2 : rr_q - 2'd1;
    win_d  = req[rr_q] ? rr_q : req[nxt1_d] ? nxt1_d : nxt2_d;
    x_d    = (win_d == 2'd2) ? req_x[71:48] : (win_d == 2'd1) ? req_x[47:24] : req_x[23:0];
    y_d    = (win_d == 2'd2) ? req_y[71:48] : (win_d == 2'd1) ? req_y[47:24] : req_y[23:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rsp_valid_q <= '0;
      crd_x_q     <= '0;
      crd_y_q     <= '0;
      ang_q       <= '0;
      mag_q       <= '0;
      err_q       <= 1'b0;
      crd_start_q <= 1'b0;
    end else begin
      ack_q       <= '0;
      rsp_valid_q <= '0;
      crd_start_q <= 1'b0;
      case (state_q)
        IDLE: if (|req) begin
          grant_q     <= win_d;
          crd_x_q     <= x_d;
          crd_y_q     <= y_d;
          ack_q       <= 3'b001 << win_d;
          crd_start_q <= 1'b1;
          state_q     <= START;
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        // crd_done takes priority over the timeout on the terminal cycle
        WAIT: if (crd_done) begin
          ang_q       <= crd_angle;
          mag_q       <= crd_magnitude;
          err_q       <= 1'b0;
          rsp_valid_q <= 3'b001 << grant_q;
          state_q     <= RESP;
        end else if (cnt_q == LAST) begin
          ang_q       <= '0;
          mag_q       <= '0;
          err_q       <= 1'b1;
          rsp_valid_q <= 3'b001 << grant_q;
          state_q     <= RESP;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        RESP: begin
          rr_q    <= (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ack           = ack_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_angle     = ang_q;
  assign rsp_magnitude = mag_q;
  assign rsp_err       = err_q;
  assign busy          = state_q != IDLE;
  assign crd_x         = crd_x_q;
  assign crd_y         = crd_y_q;
  assign crd_start     = crd_start_q;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: scoreboard bench; two arbiters (default and 8-cycle timeout) share stimulus,
// only the one selected by use8 sees requests, and a model CORDIC answers dly cycles after start.
module tb_cordic_arbiter;
  typedef struct {int idx; int cyc; logic [23:0] ang; logic [23:0] mag; logic err;} exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic [2:0]  req = '0;
  logic [71:0] req_x = '0, req_y = '0;
  logic        use8 = 0, done_m = 0, stray = 0, echo = 0;
  logic [23:0] mdl_ang = '0, mdl_mag = '0;
  int dly = 0, cyc = 0, checks = 0, errors = 0, c0;
  exp_t eq_ack[$], eq_rsp[$], ea, er;
  logic [23:0] xs [3], ys [3];
  logic [2:0]  ack_a, ack_b, rv_a, rv_b, ack_m, rv_m;
  logic [23:0] ang_a, ang_b, mag_a, mag_b, cx_a, cx_b, cy_a, cy_b, ang_m, mag_m, cx_m, cy_m, cang, cmag;
  logic        err_a, err_b, busy_a, busy_b, cs_a, cs_b, err_m, busy_m, cs_m, done_w;
  assign done_w = done_m | stray;
  assign ack_m  = use8 ? ack_b : ack_a;
  assign rv_m   = use8 ? rv_b : rv_a;
  assign ang_m  = use8 ? ang_b : ang_a;
  assign mag_m  = use8 ? mag_b : mag_a;
  assign cx_m   = use8 ? cx_b : cx_a;
  assign cy_m   = use8 ? cy_b : cy_a;
  assign err_m  = use8 ? err_b : err_a;
  assign busy_m = use8 ? busy_b : busy_a;
  assign cs_m   = use8 ? cs_b : cs_a;
  assign cang   = echo ? cx_m : mdl_ang;
  assign cmag   = echo ? cy_m : mdl_mag;

  cordic_arbiter dut_a (
    .clk(clk), .rst_n(rst_n), .req(use8 ? 3'b000 : req), .req_x(req_x), .req_y(req_y),
    .ack(ack_a), .rsp_valid(rv_a), .rsp_angle(ang_a), .rsp_magnitude(mag_a), .rsp_err(err_a),
    .busy(busy_a), .crd_x(cx_a), .crd_y(cy_a), .crd_start(cs_a),
    .crd_done(done_w & !use8), .crd_angle(cang), .crd_magnitude(cmag));
  cordic_arbiter #(.TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(use8 ? req : 3'b000), .req_x(req_x), .req_y(req_y),
    .ack(ack_b), .rsp_valid(rv_b), .rsp_angle(ang_b), .rsp_magnitude(mag_b), .rsp_err(err_b),
    .busy(busy_b), .crd_x(cx_b), .crd_y(cy_b), .crd_start(cs_b),
    .crd_done(done_w & use8), .crd_angle(cang), .crd_magnitude(cmag));

  always @(posedge clk) cyc <= cyc + 1;

  // model CORDIC: done pulse dly cycles after the start cycle; dly==0 never answers
  int d;
  always begin
    do @(negedge clk); while (!cs_m);
    d = dly;
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1 done_m = 1;
      @(posedge clk);
      #1 done_m = 0;
    end
  end

  function automatic logic [2:0] oh(input int i);
    return 3'b001 << i;
  endfunction

  always @(negedge clk) begin
    if (|ack_m || cs_m) begin
      checks++;
      if (eq_ack.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got ack=%b start=%b cyc=%0d", ack_m, cs_m, cyc);
      end else begin
        ea = eq_ack.pop_front();
        if (ack_m !== oh(ea.idx) || cs_m !== 1'b1 || cyc != ea.cyc) begin
          errors++;
          $display("FAIL ack got ack=%b start=%b cyc=%0d exp ack=%b start=1 cyc=%0d",
                   ack_m, cs_m, cyc, oh(ea.idx), ea.cyc);
        end
      end
    end
    if (|rv_m) begin
      checks++;
      if (eq_rsp.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got valid=%b cyc=%0d", rv_m, cyc);
      end else begin
        er = eq_rsp.pop_front();
        if (rv_m !== oh(er.idx) || ang_m !== er.ang || mag_m !== er.mag || err_m !== er.err || cyc != er.cyc) begin
          errors++;
          $display("FAIL rsp got valid=%b ang=%h mag=%h err=%b cyc=%0d exp valid=%b ang=%h mag=%h err=%b cyc=%0d",
                   rv_m, ang_m, mag_m, err_m, cyc, oh(er.idx), er.ang, er.mag, er.err, er.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic push_ack(input int idx, input int c);
    eq_ack.push_back('{idx, c, 24'h0, 24'h0, 1'b0});
  endtask

  task automatic push_rsp(input int idx, input int c, input logic [23:0] a, input logic [23:0] m, input logic e);
    eq_rsp.push_back('{idx, c, a, m, e});
  endtask

  task automatic op(input logic [2:0] r, input int hold);
    req = r;
    repeat (hold) @(posedge clk);
    #1 req = '0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((eq_ack.size() != 0 || eq_rsp.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (eq_ack.size() != 0 || eq_rsp.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got pending ack=%0d rsp=%0d exp 0", nm, eq_ack.size(), eq_rsp.size());
      eq_ack.delete();
      eq_rsp.delete();
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {ack_a, rv_a, cs_a, busy_a, err_a, ack_b, rv_b, cs_b, busy_b, err_b}, 24'h0);
    chk("rst_res", ang_a | mag_a | cx_a | cy_a | ang_b | mag_b | cx_b | cy_b, 24'h0);
    rst_n = 1;
    @(posedge clk);
    #1;
    // single request
    req_x[23:0] = 24'hFFE000; req_y[23:0] = 24'h00376C;
    mdl_ang = 24'h00AAAA; mdl_mag = 24'h004000; dly = 18;
    c0 = cyc; push_ack(0, c0 + 1); push_rsp(0, c0 + 20, 24'h00AAAA, 24'h004000, 1'b0);
    op(3'b001, 2);
    chk("crd_x", cx_m, 24'hFFE000);
    chk("crd_y", cy_m, 24'h00376C);
    chk("busy_wait", 24'(busy_m), 24'h1);
    drain("single");
    chk("crd_x_hold", cx_m, 24'hFFE000);
    chk("busy_idle", 24'(busy_m), 24'h0);
    // stray done in IDLE then in START
    stray = 1;
    @(posedge clk);
    #1 stray = 0;
    @(negedge clk);
    chk("stray_idle_busy", 24'(busy_m), 24'h0);
    @(posedge clk);
    #1;
    mdl_ang = 24'h800001; mdl_mag = 24'h7FFFFF; dly = 5;
    c0 = cyc; push_ack(0, c0 + 1); push_rsp(0, c0 + 7, 24'h800001, 24'h7FFFFF, 1'b0);
    req = 3'b001;
    @(posedge clk);
    #1 stray = 1;
    @(posedge clk);
    #1 stray = 0; req = '0;
    drain("stray");
    // reset mid-WAIT, late done ignored
    dly = 12;
    c0 = cyc; push_ack(0, c0 + 1);
    op(3'b001, 2);
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("midrst_ctl", {ack_m, rv_m, cs_m, busy_m, err_m}, 24'h0);
    chk("midrst_res", ang_m | mag_m | cx_m | cy_m, 24'h0);
    @(posedge clk);
    #1 rst_n = 1;
    repeat (9) @(posedge clk);
    #1;
    chk("late_done_busy", 24'(busy_m), 24'h0);
    mdl_ang = 24'h000123; mdl_mag = 24'h000456; dly = 3;
    c0 = cyc; push_ack(2, c0 + 1); push_rsp(2, c0 + 5, 24'h000123, 24'h000456, 1'b0);
    op(3'b100, 2);
    drain("after_reset");
    // round robin with all requests held
    xs = '{24'h000100, 24'h000200, 24'h000300};
    ys = '{24'h000010, 24'h000020, 24'h000030};
    req_x = {xs[2], xs[1], xs[0]}; req_y = {ys[2], ys[1], ys[0]};
    echo = 1; dly = 2;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      push_ack(k % 3, c0 + 1 + 5 * k);
      push_rsp(k % 3, c0 + 4 + 5 * k, xs[k % 3], ys[k % 3], 1'b0);
    end
    op(3'b111, 27);
    drain("round_robin");
    echo = 0;
    // 8-cycle timeout arbiter: done on the terminal cycle wins
    use8 = 1;
    mdl_ang = 24'h123456; mdl_mag = 24'h0789AB; dly = 8;
    c0 = cyc; push_ack(0, c0 + 1); push_rsp(0, c0 + 10, 24'h123456, 24'h0789AB, 1'b0);
    op(3'b001, 2);
    drain("simultaneous");
    dly = 0;
    c0 = cyc; push_ack(1, c0 + 1); push_rsp(1, c0 + 10, 24'h0, 24'h0, 1'b1);
    op(3'b010, 2);
    drain("timeout");
    chk("err_hold", 24'(err_m), 24'h1);
    mdl_ang = 24'h00F00D; mdl_mag = 24'h000ABC; dly = 3;
    c0 = cyc; push_ack(2, c0 + 1); push_rsp(2, c0 + 5, 24'h00F00D, 24'h000ABC, 1'b0);
    op(3'b100, 2);
    drain("post_timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 64, max cycles in WAIT before aborting an operation (range 2..255).
REQ-002 One clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  3  per-requester operation request, held high with stable operands until ack.
REQ-006 req_x  input  72  three signed 24-bit x operands; requester i uses bits [24i+23:24i].
REQ-007 req_y  input  72  three signed 24-bit y operands, same packing as req_x.
REQ-008 ack  output  3  one-hot single-cycle pulse: operands of requester i captured.
REQ-009 rsp_valid  output  3  one-hot single-cycle pulse: result for requester i on rsp_* this cycle.
REQ-010 rsp_angle  output  24  signed angle result, valid with rsp_valid.
REQ-011 rsp_magnitude  output  24  signed magnitude result, valid with rsp_valid.
REQ-012 rsp_err  output  1  high with rsp_valid when the operation timed out.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 crd_x, crd_y  output  24 each  registered operands driven to the CORDIC unit.
REQ-015 crd_start  output  1  single-cycle start pulse to the CORDIC unit.
REQ-016 crd_done  input  1  single-cycle completion pulse from the CORDIC unit.
REQ-017 crd_angle, crd_magnitude  input  24 each  CORDIC results, valid while crd_done is high.

Function
REQ-018 FSM states IDLE, START, WAIT, RESP; encoding is free.
REQ-019 IDLE: if req is nonzero, grant by round-robin from pointer rr (0..2), checking rr, rr+1, rr+2 mod 3; latch the winner's operands into crd_x/crd_y and its index into grant; go to START. Otherwise stay in IDLE.
REQ-020 START: ack[grant]=1 and crd_start=1 for exactly this cycle; clear timeout counter; go to WAIT.
REQ-021 WAIT: crd_done is sampled only in this state. On crd_done=1, latch crd_angle/crd_magnitude, rsp_err=0, go to RESP.
REQ-022 WAIT: the counter increments each cycle. When it reaches TIMEOUT_CYC-1 without crd_done, set rsp_angle=0, rsp_magnitude=0, rsp_err=1 and go to RESP.
REQ-023 crd_done and timeout in the same cycle: crd_done wins and rsp_err=0.
REQ-024 RESP: rsp_valid[grant]=1 for exactly this cycle; rr <= (grant+1) mod 3; go to IDLE.
REQ-025 rsp_angle, rsp_magnitude and rsp_err hold their values until the next RESP.
REQ-026 crd_x and crd_y hold their values from capture until the next grant.
REQ-027 crd_done outside WAIT is ignored and causes no state change.
REQ-028 req bits are sampled only in IDLE.
REQ-029 A requester dropping req before its grant is legal and loses no state.
REQ-030 A request asserted during a busy operation waits for IDLE.
REQ-031 Latency: req seen in IDLE at edge N gives ack and crd_start at cycle N+1. crd_done at cycle M gives rsp_valid at cycle M+1. Back-to-back grants are 4+ cycles apart.
REQ-032 Results pass through unmodified; no sign or width conversion.

Reset
REQ-033 rst_n low immediately forces IDLE; ack=0, rsp_valid=0, crd_start=0, busy=0, rsp_err=0; rsp_angle, rsp_magnitude, crd_x and crd_y = 0; rr=0; counter=0.
REQ-034 Reset mid-operation abandons the operation with no rsp_valid. A later crd_done from the abandoned operation is ignored per REQ-027.

Verification
REQ-035 Single request: req=3'b001, x=-8192, y=14188; model CORDIC returns done 18 cycles after start with angle=24'h00AAAA, mag=24'h004000 -> ack=001 and crd_start one cycle after req; crd_x=-8192; rsp_valid=001 the cycle after done with those values and rsp_err=0.
REQ-036 Round-robin: req=3'b111 held, all requests re-raised after each ack -> grant order 0,1,2,0,1,2, each ack a single pulse, never two grants in flight.
REQ-037 Timeout: TIMEOUT_CYC=8 and the model never asserts done -> rsp_valid pulses for the granted requester 8 WAIT cycles after START, with rsp_err=1, angle=0 and mag=0; the next request is still served.
REQ-038 Stray done: crd_done pulsed in IDLE and in START -> no rsp_valid, no state change, and the operation still completes on the real done.
REQ-039 Reset mid-WAIT: rst_n pulsed low 5 cycles after START -> all outputs 0 at once; a late crd_done yields no rsp_valid; the next req=3'b100 is granted to requester 2, since rr=0 and only requester 2 is requesting.
REQ-040 Simultaneous timeout and done on the terminal cycle -> rsp_err=0 and the CORDIC results are returned.
